fifo_param: RTL and testbench



---
 rtl/fifo_param.sv | 83 ++++++++
 tb/tb_fifo_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO. The count register is authoritative and all status
// flags decode from it. Overflow and underflow are reported as one-cycle registered pulses.
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_n,
    input  logic                       wr_n,
    input  logic                       rd_n,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       over_flow,
    output logic                       under_flow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
    assign rd_ok = !rd_n && (count != '0);
    assign wr_ok = !wr_n && ((count != FULL_CNT) || rd_ok);

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Storage is never reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (flush_n && wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
        end else if (!flush_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
        end else begin
            over_flow  <= !wr_n && !wr_ok;
            under_flow <= !rd_n && !rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the FIFO's acceptance rules.
module tb_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_n;
    logic              wr_n;
    logic              rd_n;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [4:0]        count;
    logic              full, empty, almost_full, almost_empty, over_flow, under_flow;

    fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .flush_n(flush_n), .wr_n(wr_n), .rd_n(rd_n),
        .data_in(data_in), .data_out(data_out), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .over_flow(over_flow), .under_flow(under_flow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] dout_m;
    logic              ovf_m;
    logic              unf_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input bit rd, input bit fl, input logic [DATA_W-1:0] din);
        bit racc, wacc;
        if (fl) begin
            q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            racc = rd && (q.size() > 0);
            wacc = wr && ((q.size() < DEPTH) || racc);
            if (racc) dout_m = q.pop_front();
            if (wacc) q.push_back(din);
            ovf_m = wr && !wacc;
            unf_m = rd && !racc;
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".dout"}, 32'(data_out), 32'(dout_m));
        chk({tag, ".ovf"}, 32'(over_flow), 32'(ovf_m));
        chk({tag, ".unf"}, 32'(under_flow), 32'(unf_m));
    endtask

    // Called at a falling edge; drives one cycle of requests and checks after the next rise.
    task automatic step(input string tag, input bit wr, input bit rd, input bit fl,
                        input logic [DATA_W-1:0] din);
        wr_n    = !wr;
        rd_n    = !rd;
        flush_n = !fl;
        data_in = din;
        @(posedge clk);
        model_edge(wr, rd, fl, din);
        @(negedge clk);
        compare_all(tag);
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        flush_n = 1'b1;
    endtask

    initial begin
        int ovf_cycles;
        int unf_cycles;
        rst_n   = 1'b0;
        flush_n = 1'b1;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        data_in = '0;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 16..1, then two rejected writes.
        ovf_cycles = 0;
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 8'(DEPTH - i));
        chk("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < 2; i++) begin
            step("ovf", 1, 0, 0, 8'd1);
            ovf_cycles += int'(over_flow);
        end
        step("ovf_end", 0, 0, 0, 8'd0);
        ovf_cycles += int'(over_flow);
        chk("ovf_cycles", 32'(ovf_cycles), 32'd2);

        // Drain 16, then two rejected reads.
        unf_cycles = 0;
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            step("unf", 0, 1, 0, 8'd0);
            unf_cycles += int'(under_flow);
        end
        step("unf_end", 0, 0, 0, 8'd0);
        unf_cycles += int'(under_flow);
        chk("unf_cycles", 32'(unf_cycles), 32'd2);
        chk("drain_hold", 32'(data_out), 32'd1);

        // Simultaneous read and write while full.
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 0, 0, 8'(DEPTH - i));
        step("full_rw", 1, 1, 0, 8'hA5);
        chk("full_rw_dout", 32'(data_out), 32'd16);
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, 1, 0, 8'd0);
        chk("a5_last", 32'(data_out), 32'hA5);

        // Simultaneous read and write while empty.
        step("empty_rw", 1, 1, 0, 8'h3C);
        chk("empty_rw_unf", 32'(under_flow), 32'd1);
        step("empty_rw2", 0, 1, 0, 8'd0);
        chk("3c_read", 32'(data_out), 32'h3C);

        // Flush with both requests active.
        for (int i = 0; i < 5; i++) step("pre_flush", 1, 0, 0, 8'(8'h50 + i));
        step("flush", 1, 1, 1, 8'hEE);
        step("post_flush_wr", 1, 0, 0, 8'h77);
        step("post_flush_rd", 0, 1, 0, 8'd0);
        chk("flush_new", 32'(data_out), 32'h77);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) step("wrap_w", 1, 0, 0, 8'(i + 100));
        for (int i = 0; i < 10; i++) step("wrap_r", 0, 1, 0, 8'd0);
        for (int i = 0; i < DEPTH; i++) step("wrap_w2", 1, 0, 0, 8'(i));
        for (int i = 0; i < DEPTH; i++) begin
            step("wrap_r2", 0, 1, 0, 8'd0);
            chk("wrap_seq", 32'(data_out), 32'(i));
        end

        // Random traffic with varying bias.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = (i / 500) % 2 == 0 ? 70 : 30;
            step("rand", $urandom_range(99) < wp, $urandom_range(99) < 100 - wp,
                 $urandom_range(99) < 2, 8'($urandom));
        end

        // Asynchronous reset between edges, mid-burst.
        for (int i = 0; i < 6; i++) step("pre_rst", 1, 0, 0, 8'(8'h90 + i));
        step("pre_rst_rd", 0, 1, 0, 8'd0);
        wr_n    = 1'b0;
        data_in = 8'hAB;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ae", 32'(almost_empty), 32'd1);
        chk("arst_af", 32'(almost_full), 32'd0);
        chk("arst_dout", 32'(data_out), 32'd0);
        chk("arst_ovf", 32'(over_flow), 32'd0);
        chk("arst_unf", 32'(under_flow), 32'd0);
        @(negedge clk);
        wr_n  = 1'b1;
        rst_n = 1'b1;
        model_reset();
        compare_all("arst_rel");
        step("arst_wr", 1, 0, 0, 8'h5A);
        step("arst_rd", 0, 1, 0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
